// File: rtl/sha256_iter_core.sv
// ---------------------------------------------------------------------------
// sha256_iter_core
//
// Iterative SHA-256 compression engine. It accepts one pre-padded 512-bit
// message block at a time, evaluates ROUNDS_PER_CYCLE rounds per clock and
// applies the feed-forward addition. The finished digest is also kept as the
// chaining value for the next block.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   in_valid    block present on in_block
//   in_ready    core can accept a block (IDLE only)
//   in_block    padded block, [511:480] = W0 ... [31:0] = W15
//   in_first    1: start from the SHA-256 IV, 0: chain from previous digest
//   out_valid   digest valid (DONE), held until out_ready
//   out_ready   consumer accepts the digest
//   out_digest  [255:224] = H0 ... [31:0] = H7, held between deliveries
//   busy        high in ROUND or DONE
// ---------------------------------------------------------------------------
module sha256_iter_core #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [511:0] in_block,
    input  logic         in_first,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [255:0] out_digest,
    output logic         busy
);

    localparam int R            = ROUNDS_PER_CYCLE;
    localparam int ROUND_CYCLES = 64 / R;
    // Counter value of the final compute cycle of a block.
    localparam logic [5:0] LAST_CNT = 6'((ROUND_CYCLES - 1) * R);
    localparam logic [5:0] CNT_STEP = 6'(R);

    generate
        if ((R != 1 && R != 2 && R != 4 && R != 8) || (ROUND_CYCLES * R != 64)) begin : g_bad_rounds
            $error("sha256_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
        end
    endgenerate

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    // -----------------------------------------------------------------------
    // SHA-256 primitive functions (all arithmetic mod 2^32)
    // -----------------------------------------------------------------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    state_t       state_q;
    logic [5:0]   cnt_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;
    logic [255:0] digest_q;
    logic [255:0] chain_q;

    // Datapath registers; contents are only meaningful while a block is
    // in flight, so they carry no reset.
    logic [31:0]  win_q  [16];   // win_q[0] holds W[t] for the current counter
    logic [31:0]  wk_q   [8];    // working variables a..h
    logic [31:0]  base_q [8];    // H at block start, for the feed-forward

    // Combinational next-state values
    logic [31:0]  base_h [8];
    logic [31:0]  ext    [16 + R];
    logic [31:0]  win_d  [16];
    logic [31:0]  st     [R + 1][8];
    logic [31:0]  t1;
    logic [31:0]  t2;
    logic [5:0]   kidx;
    logic [255:0] digest_d;

    // Starting hash value for an accepted block.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            base_h[i] = in_first ? IV[255 - 32*i -: 32] : chain_q[255 - 32*i -: 32];
        end
    end

    // R chained rounds. The window is extended by R words so that rounds
    // beyond W[t+15] can draw on words produced earlier in the same cycle.
    always_comb begin
        for (int i = 0; i < 16 + R; i++) begin
            ext[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            ext[i] = win_q[i];
        end
        for (int j = 0; j < R; j++) begin
            ext[16 + j] = ssig1(ext[14 + j]) + ext[9 + j] + ssig0(ext[1 + j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) begin
            win_d[i] = ext[i + R];
        end

        t1   = '0;
        t2   = '0;
        kidx = '0;
        for (int j = 0; j <= R; j++) begin
            for (int i = 0; i < 8; i++) begin
                st[j][i] = '0;
            end
        end
        for (int i = 0; i < 8; i++) begin
            st[0][i] = wk_q[i];
        end
        for (int j = 0; j < R; j++) begin
            kidx = cnt_q + 6'(j);
            t1 = st[j][7] + bsig1(st[j][4]) + ch(st[j][4], st[j][5], st[j][6])
               + K_TAB[kidx] + ext[j];
            t2 = bsig0(st[j][0]) + maj(st[j][0], st[j][1], st[j][2]);
            st[j + 1][0] = t1 + t2;
            st[j + 1][1] = st[j][0];
            st[j + 1][2] = st[j][1];
            st[j + 1][3] = st[j][2];
            st[j + 1][4] = st[j][3] + t1;
            st[j + 1][5] = st[j][4];
            st[j + 1][6] = st[j][5];
            st[j + 1][7] = st[j][6];
        end

        digest_d = '0;
        for (int i = 0; i < 8; i++) begin
            digest_d[255 - 32*i -: 32] = base_q[i] + st[R][i];
        end
    end

    // -----------------------------------------------------------------------
    // Control FSM with registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            digest_q    <= '0;
            chain_q     <= IV;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        state_q    <= S_ROUND;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                S_ROUND: begin
                    cnt_q <= cnt_q + CNT_STEP;
                    if (cnt_q == LAST_CNT) begin
                        digest_q    <= digest_d;
                        chain_q     <= digest_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: load on accept, advance R rounds per ROUND cycle
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && in_valid && in_ready_q) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= in_block[511 - 32*i -: 32];
            end
            for (int i = 0; i < 8; i++) begin
                wk_q[i]   <= base_h[i];
                base_q[i] <= base_h[i];
            end
        end else if (state_q == S_ROUND) begin
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
            for (int i = 0; i < 8; i++) begin
                wk_q[i] <= st[R][i];
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign out_digest = digest_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// ---------------------------------------------------------------------------
// tb_sha256_iter_core
//
// Four instances of sha256_iter_core (1, 2, 4 and 8 rounds per cycle) driven
// one after another. Expected digests are pushed into per-instance queues when
// a block is accepted; a monitor pops and compares on every output handshake.
// Expectations come from known-answer digests or from a full-schedule SHA-256
// compression model.
// ---------------------------------------------------------------------------
module tb_sha256_iter_core;

    localparam logic [255:0] IV_C = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [511:0] ABC_B   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] EMPTY_B = {32'h80000000, 480'h0};
    localparam logic [511:0] TWO_B1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] TWO_B2  = {448'h0, 32'h00000000, 32'h000001c0};

    localparam logic [255:0] ABC_D   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_D   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk;
    logic         rst_n;
    logic         in_valid_v   [4];
    logic         in_ready_v   [4];
    logic [511:0] in_block_a   [4];
    logic         in_first_v   [4];
    logic         out_valid_v  [4];
    logic         out_ready_v  [4];
    logic [255:0] out_digest_a [4];
    logic         busy_v       [4];

    int           checks;
    int           failures;
    logic [255:0] exp_mem  [4][16];
    int           wr_ptr   [4];
    int           rd_ptr   [4];
    logic [255:0] ref_chain[4];

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_iter_core #(.ROUNDS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .in_block  (in_block_a[g]),
            .in_first  (in_first_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .out_digest(out_digest_a[g]),
            .busy      (busy_v[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0]  w [64];
        logic [31:0]  h [8];
        logic [31:0]  v [8];
        logic [31:0]  s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) begin
            h[i] = hin[255 - 32*i -: 32];
            v[i] = h[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rnd_blk();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
        return b;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (rst_n && out_valid_v[k] && out_ready_v[k]) begin
                    if (rd_ptr[k] == wr_ptr[k]) begin
                        checks++;
                        failures++;
                        $display("FAIL spurious_out_k%0d: got digest %h with no block pending", k, out_digest_a[k]);
                    end else begin
                        chk($sformatf("digest_k%0d_n%0d", k, rd_ptr[k]), out_digest_a[k],
                            exp_mem[k][rd_ptr[k] % 16]);
                        rd_ptr[k]++;
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus ----------------
    // Presents a block, waits for acceptance and records the expected digest.
    // Returns 1 time unit after the accepting edge.
    task automatic start_block(input int k, input logic [511:0] blk, input logic first,
                               input logic use_kat, input logic [255:0] kat);
        logic [255:0] e;
        int n;
        in_block_a[k] = blk;
        in_first_v[k] = first;
        in_valid_v[k] = 1'b1;
        n = 0;
        while (!in_ready_v[k] && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout_k%0d: in_ready got 0 expected 1", k);
        end
        e = sha_compress(first ? IV_C : ref_chain[k], blk);
        if (use_kat) e = kat;
        ref_chain[k] = e;
        exp_mem[k][wr_ptr[k] % 16] = e;
        wr_ptr[k]++;
        @(posedge clk); #1;
        in_valid_v[k] = 1'b0;
    endtask

    task automatic wait_out(input int k, input string name);
        int n;
        n = 0;
        while (!out_valid_v[k] && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk($sformatf("latency_%s_k%0d", name, k), 256'(n), 256'(64 >> k));
    endtask

    task automatic collect(input int k);
        out_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        out_ready_v[k] = 1'b0;
    endtask

    task automatic backpressure(input int k);
        start_block(k, rnd_blk(), 1'b1, 1'b0, '0);
        wait_out(k, "bp");
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("bp_valid_k%0d", k), 256'(out_valid_v[k]), 256'd1);
            chk($sformatf("bp_digest_k%0d", k), out_digest_a[k], ref_chain[k]);
            chk($sformatf("bp_in_ready_k%0d", k), 256'(in_ready_v[k]), 256'd0);
            if (i == 5) begin
                in_block_a[k] = rnd_blk();
                in_first_v[k] = 1'b1;
                in_valid_v[k] = 1'b1;
            end
            if (i == 6) in_valid_v[k] = 1'b0;
            @(posedge clk); #1;
        end
        collect(k);
        chk($sformatf("bp_idle_ready_k%0d", k), 256'(in_ready_v[k]), 256'd1);
        chk($sformatf("bp_idle_valid_k%0d", k), 256'(out_valid_v[k]), 256'd0);
        chk($sformatf("bp_idle_busy_k%0d", k), 256'(busy_v[k]), 256'd0);
        chk($sformatf("bp_retain_k%0d", k), out_digest_a[k], ref_chain[k]);
        // Chains from the stalled block's digest; the pulsed block must not count.
        start_block(k, rnd_blk(), 1'b0, 1'b0, '0);
        wait_out(k, "bp_chain");
        collect(k);
    endtask

    task automatic busy_reject(input int k);
        logic [511:0] ba, bb;
        logic [255:0] e;
        int acc, last_acc, cyc, n;
        ba = rnd_blk();
        bb = rnd_blk();
        acc = 0;
        last_acc = -1;
        cyc = 0;
        out_ready_v[k] = 1'b1;
        in_valid_v[k] = 1'b1;
        while (acc < 4 && cyc < 2000) begin
            in_block_a[k] = (cyc % 2 == 0) ? ba : bb;
            in_first_v[k] = (cyc % 3 == 0);
            if (in_ready_v[k]) begin
                e = sha_compress(in_first_v[k] ? IV_C : ref_chain[k], in_block_a[k]);
                ref_chain[k] = e;
                exp_mem[k][wr_ptr[k] % 16] = e;
                wr_ptr[k]++;
                if (last_acc >= 0)
                    chk($sformatf("accept_spacing_k%0d", k), 256'(cyc - last_acc), 256'((64 >> k) + 2));
                last_acc = cyc;
                acc++;
            end
            @(posedge clk); #1; cyc++;
        end
        in_valid_v[k] = 1'b0;
        chk($sformatf("busy_accepts_k%0d", k), 256'(acc), 256'd4);
        n = 0;
        while (rd_ptr[k] != wr_ptr[k] && n < 300) begin
            @(posedge clk); #1; n++;
        end
        out_ready_v[k] = 1'b0;
    endtask

    task automatic mid_reset(input int k);
        int wait_n;
        wait_n = (k == 0) ? 30 : ((64 >> k) / 2);
        start_block(k, ABC_B, 1'b1, 1'b1, ABC_D);
        repeat (wait_n) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk($sformatf("rst_valid_k%0d", k), 256'(out_valid_v[k]), 256'd0);
        chk($sformatf("rst_ready_k%0d", k), 256'(in_ready_v[k]), 256'd1);
        chk($sformatf("rst_busy_k%0d", k), 256'(busy_v[k]), 256'd0);
        rd_ptr[k] = wr_ptr[k];
        for (int i = 0; i < 4; i++) ref_chain[i] = IV_C;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_block(k, ABC_B, 1'b0, 1'b1, ABC_D);
        wait_out(k, "abc_after_rst");
        collect(k);
    endtask

    task automatic run_suite(input int k);
        start_block(k, ABC_B, 1'b1, 1'b1, ABC_D);
        wait_out(k, "abc");
        collect(k);
        start_block(k, EMPTY_B, 1'b1, 1'b1, EMPTY_D);
        wait_out(k, "empty");
        collect(k);
        start_block(k, TWO_B1, 1'b1, 1'b0, '0);
        wait_out(k, "two_b1");
        collect(k);
        start_block(k, TWO_B2, 1'b0, 1'b1, TWO_D);
        wait_out(k, "two_b2");
        collect(k);
        for (int i = 0; i < 3; i++) begin
            start_block(k, rnd_blk(), 1'($urandom_range(1, 0)), 1'b0, '0);
            wait_out(k, "rand");
            collect(k);
        end
        backpressure(k);
        busy_reject(k);
        mid_reset(k);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid_v[k]  = 1'b0;
            in_block_a[k]  = '0;
            in_first_v[k]  = 1'b0;
            out_ready_v[k] = 1'b0;
            wr_ptr[k]      = 0;
            rd_ptr[k]      = 0;
            ref_chain[k]   = IV_C;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        fork
            monitor();
        join_none
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("reset_in_ready_k%0d", k), 256'(in_ready_v[k]), 256'd1);
            chk($sformatf("reset_out_valid_k%0d", k), 256'(out_valid_v[k]), 256'd0);
            chk($sformatf("reset_busy_k%0d", k), 256'(busy_v[k]), 256'd0);
            chk($sformatf("reset_digest_k%0d", k), out_digest_a[k], 256'd0);
        end
        for (int k = 0; k < 4; k++) begin
            run_suite(k);
        end
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drained_k%0d", k), 256'(wr_ptr[k] - rd_ptr[k]), 256'd0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
